branch_resolve_ctrl: RTL and testbench

// ID-stage controller that sequences the branch comparator. Decodes the branch type into the comparator op.

---
 rtl/branch_resolve_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch sequencer: decodes the comparator op, stalls for operands, and resolves taken/not-taken for NPC.
// Optional performance counters are built when BR_PERF_CNT_EN is defined; otherwise perf_* outputs are tied to zero.
module branch_resolve_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic [3:0]       br_type,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic             cmp_result,
    input  logic             id_stall_ext,
    input  logic             ex_flush,
    output logic [2:0]       cmp_op,
    output logic             br_stall,
    output logic             br_resolve,
    output logic             br_taken,
    output logic             br_hang,
    output logic [CNT_W-1:0] perf_br,
    output logic [CNT_W-1:0] perf_taken,
    output logic [CNT_W-1:0] perf_stall
);

    // state   | meaning
    // IDLE    | no branch pending; a ready branch resolves here with zero latency
    // WAIT    | branch stalled waiting for rs/rt to become forwardable
    // HOLD    | decision already made; replayed from taken_q while ID is stalled externally
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(WAIT_MAX);

    state_t            state_q;
    state_t            state_d;
    logic              taken_q;
    logic              taken_d;
    logic [WCNT_W-1:0] wait_cnt_q;
    logic [WCNT_W-1:0] wait_cnt_d;
    logic              br_hang_q;
    logic              hang_set;

    logic              active;
    logic              need_rs;
    logic              need_rt;
    logic              ready;
    logic              dec_taken;
    logic [2:0]        op_dec;

    assign active    = br_valid & ~br_type[3];
    assign ready     = (~need_rs | rs_ready) & (~need_rt | rt_ready);
    assign dec_taken = (br_type == 4'd7) ? 1'b1 : cmp_result;

    always_comb begin
        op_dec  = 3'b000;
        need_rs = 1'b0;
        need_rt = 1'b0;
        case (br_type)
            4'd0, 4'd1: begin
                op_dec  = br_type[2:0];
                need_rs = 1'b1;
                need_rt = 1'b1;
            end
            4'd2, 4'd3, 4'd4, 4'd5: begin
                op_dec  = br_type[2:0];
                need_rs = 1'b1;
            end
            4'd6: begin
                op_dec  = br_type[2:0];
                need_rt = 1'b1;
            end
            default: begin
                op_dec = 3'b000;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        taken_d    = taken_q;
        wait_cnt_d = wait_cnt_q;
        hang_set   = 1'b0;
        cmp_op     = 3'b000;
        br_stall   = 1'b0;
        br_resolve = 1'b0;
        br_taken   = 1'b0;
        if (reset) begin
            state_d    = ST_IDLE;
        end else if (ex_flush || !active) begin
            // taken_q is deliberately left alone on a flush
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
        end else begin
            cmp_op = op_dec;
            if (state_q == ST_HOLD) begin
                br_resolve = 1'b1;
                br_taken   = taken_q;
                if (!id_stall_ext) begin
                    state_d = ST_IDLE;
                end
            end else if (ready) begin
                br_resolve = 1'b1;
                br_taken   = dec_taken;
                wait_cnt_d = '0;
                if (id_stall_ext) begin
                    taken_d = dec_taken;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                br_stall = 1'b1;
                state_d  = ST_WAIT;
                if (state_q == ST_IDLE) begin
                    wait_cnt_d = WCNT_W'(1);
                end else if (wait_cnt_q != WAIT_LIM) begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
                hang_set = (wait_cnt_d == WAIT_LIM);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            taken_q    <= 1'b0;
            wait_cnt_q <= '0;
            br_hang_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            taken_q    <= taken_d;
            wait_cnt_q <= wait_cnt_d;
            if (hang_set) begin
                br_hang_q <= 1'b1;
            end
        end
    end

    assign br_hang = br_hang_q & ~reset;

`ifdef BR_PERF_CNT_EN
    logic             first_resolve;
    logic [CNT_W-1:0] perf_br_q;
    logic [CNT_W-1:0] perf_taken_q;
    logic [CNT_W-1:0] perf_stall_q;

    // HOLD replays an already-counted decision, so only IDLE/WAIT resolves count
    assign first_resolve = br_resolve & (state_q != ST_HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_br_q    <= '0;
            perf_taken_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (first_resolve) begin
                perf_br_q <= perf_br_q + CNT_W'(1);
            end
            if (first_resolve && br_taken) begin
                perf_taken_q <= perf_taken_q + CNT_W'(1);
            end
            if (br_stall) begin
                perf_stall_q <= perf_stall_q + CNT_W'(1);
            end
        end
    end

    assign perf_br    = reset ? '0 : perf_br_q;
    assign perf_taken = reset ? '0 : perf_taken_q;
    assign perf_stall = reset ? '0 : perf_stall_q;
`else
    assign perf_br    = '0;
    assign perf_taken = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_branch_resolve_ctrl;

    localparam int WAIT_MAX = 15;

    logic        clk;
    logic        reset;
    logic        br_valid;
    logic [3:0]  br_type;
    logic        rs_ready;
    logic        rt_ready;
    logic        cmp_result;
    logic        id_stall_ext;
    logic        ex_flush;
    logic [2:0]  cmp_op;
    logic        br_stall;
    logic        br_resolve;
    logic        br_taken;
    logic        br_hang;
    logic [31:0] perf_br;
    logic [31:0] perf_taken;
    logic [31:0] perf_stall;

    branch_resolve_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .br_valid     (br_valid),
        .br_type      (br_type),
        .rs_ready     (rs_ready),
        .rt_ready     (rt_ready),
        .cmp_result   (cmp_result),
        .id_stall_ext (id_stall_ext),
        .ex_flush     (ex_flush),
        .cmp_op       (cmp_op),
        .br_stall     (br_stall),
        .br_resolve   (br_resolve),
        .br_taken     (br_taken),
        .br_hang      (br_hang),
        .perf_br      (perf_br),
        .perf_taken   (perf_taken),
        .perf_stall   (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: "is a decision being held", the held value, length of the current stall streak
    bit          m_hold;
    bit          m_held;
    int          m_streak;
    bit          m_hang;
    logic [31:0] m_br;
    logic [31:0] m_tk;
    logic [31:0] m_st;
    logic [6:0]  exp_o;

    function automatic bit operands_ready();
        case (br_type)
            4'd0, 4'd1:             return rs_ready && rt_ready;
            4'd2, 4'd3, 4'd4, 4'd5: return rs_ready;
            4'd6:                   return rt_ready;
            default:                return 1'b1;
        endcase
    endfunction

    // {cmp_op, br_stall, br_resolve, br_taken, br_hang}
    function automatic logic [6:0] model_out();
        logic [2:0] op;
        logic st, rv, tk;
        op = 3'd0; st = 1'b0; rv = 1'b0; tk = 1'b0;
        if (!reset && !ex_flush && br_valid && br_type < 4'd8) begin
            op = (br_type <= 4'd6) ? br_type[2:0] : 3'd0;
            if (m_hold) begin
                rv = 1'b1; tk = m_held;
            end else if (operands_ready()) begin
                rv = 1'b1; tk = (br_type == 4'd7) ? 1'b1 : cmp_result;
            end else begin
                st = 1'b1;
            end
        end
        return {op, st, rv, tk, (m_hang && !reset)};
    endfunction

    function automatic logic [95:0] exp_perf();
`ifdef BR_PERF_CNT_EN
        return reset ? 96'd0 : {m_br, m_tk, m_st};
`else
        return 96'd0;
`endif
    endfunction

    function automatic logic [6:0] got();
        return {cmp_op, br_stall, br_resolve, br_taken, br_hang};
    endfunction

    task automatic apply(input logic v, input logic [3:0] ty, input logic rs, input logic rt,
                         input logic cr, input logic ext, input logic fl);
        br_valid = v; br_type = ty; rs_ready = rs; rt_ready = rt;
        cmp_result = cr; id_stall_ext = ext; ex_flush = fl;
        #2;
        exp_o = model_out();
    endtask

    task automatic advance();
        logic [6:0] o;
        o = model_out();
        @(posedge clk);
        if (reset) begin
            m_hold = 0; m_held = 0; m_streak = 0; m_hang = 0;
            m_br = '0; m_tk = '0; m_st = '0;
        end else if (ex_flush || !br_valid || br_type >= 4'd8) begin
            m_hold = 0; m_streak = 0;
        end else if (m_hold) begin
            m_hold = id_stall_ext;
        end else if (o[2]) begin
            m_streak = 0;
            m_br = m_br + 1;
            if (o[1]) m_tk = m_tk + 1;
            if (id_stall_ext) begin m_hold = 1; m_held = o[1]; end
        end else begin
            m_streak = (m_streak < WAIT_MAX) ? m_streak + 1 : WAIT_MAX;
            if (m_streak == WAIT_MAX) m_hang = 1;
            m_st = m_st + 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 4'(i), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (got() !== 7'd0) begin
                n_err++; $display("FAIL reset_outputs: got %b want %b", got(), 7'd0);
            end
            n_cmp++;
            if ({perf_br, perf_taken, perf_stall} !== 96'd0) begin
                n_err++; $display("FAIL reset_perf: got %h want 0", {perf_br, perf_taken, perf_stall});
            end
            advance();
        end
        reset = 1'b0;
    endtask

    task automatic test_beq_ready();
        apply(1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (got() !== {3'b000, 1'b0, 1'b1, 1'b1, 1'b0} || got() !== exp_o) begin
            n_err++; $display("FAIL beq_ready: got %b want %b", got(), exp_o);
        end
        advance();
    endtask

    task automatic test_bgtz_wait();
        logic [31:0] st0;
        st0 = perf_stall;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 4'd3, (i == 3), 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (got() !== exp_o || br_stall !== (i < 3) || br_resolve !== (i == 3)) begin
                n_err++; $display("FAIL bgtz_wait[%0d]: got %b want %b", i, got(), exp_o);
            end
            advance();
        end
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({perf_br, perf_taken, perf_stall} !== exp_perf()) begin
            n_err++; $display("FAIL bgtz_perf: got %h want %h", {perf_br, perf_taken, perf_stall}, exp_perf());
        end
`ifdef BR_PERF_CNT_EN
        n_cmp++;
        if (perf_stall - st0 !== 32'd3) begin
            n_err++; $display("FAIL bgtz_stall_count: got %0d want 3", perf_stall - st0);
        end
`endif
        advance();
    endtask

    task automatic test_hold();
        logic [31:0] br0;
        br0 = perf_br;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 4'd1, 1'b1, 1'b1, (i == 0), (i < 2), 1'b0);
            n_cmp++;
            if (got() !== exp_o || br_resolve !== 1'b1 || br_taken !== 1'b1) begin
                n_err++; $display("FAIL hold[%0d]: got %b want %b", i, got(), exp_o);
            end
            advance();
        end
        apply(1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got() !== exp_o || {perf_br, perf_taken, perf_stall} !== exp_perf()) begin
            n_err++; $display("FAIL hold_after: got %b/%h want %b/%h", got(), {perf_br, perf_taken, perf_stall}, exp_o, exp_perf());
        end
`ifdef BR_PERF_CNT_EN
        n_cmp++;
        if (perf_br - br0 !== 32'd1) begin
            n_err++; $display("FAIL hold_perf_br: got %0d want 1", perf_br - br0);
        end
`endif
        advance();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0, 1: apply(1'b1, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                2:    apply(1'b1, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
                3:    apply(1'b0, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                default: apply(1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            endcase
            n_cmp++;
            if (got() !== exp_o || ((i == 2 || i == 3) && got() !== 7'd0)) begin
                n_err++; $display("FAIL flush[%0d]: got %b want %b", i, got(), exp_o);
            end
            advance();
        end
    endtask

    task automatic test_hang();
        reset = 1'b1;
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (got() !== exp_o || br_hang !== (i == 15)) begin
                n_err++; $display("FAIL hang[%0d]: got %b want %b", i, got(), exp_o);
            end
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, (i == 1));
            n_cmp++;
            if (got() !== exp_o || br_hang !== 1'b1) begin
                n_err++; $display("FAIL hang_sticky[%0d]: got %b want %b", i, got(), exp_o);
            end
            advance();
        end
        reset = 1'b1;
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        reset = 1'b0;
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (br_hang !== 1'b0) begin
            n_err++; $display("FAIL hang_cleared: got %b want 0", br_hang);
        end
        advance();
    endtask

    task automatic test_uncond_nonbranch();
        apply(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got() !== exp_o || got() !== {3'b000, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL uncond: got %b want %b", got(), exp_o);
        end
        advance();
        apply(1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (got() !== 7'd0) begin
            n_err++; $display("FAIL nonbranch: got %b want %b", got(), 7'd0);
        end
        advance();
    endtask

    task automatic test_random();
        logic [3:0] ty;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            ty = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            apply(($urandom_range(0, 9) < 8), ty, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
                  1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
            n_cmp++;
            if (got() !== exp_o) begin
                n_err++; $display("FAIL random[%0d]: got %b want %b", i, got(), exp_o);
            end
            n_cmp++;
            if ({perf_br, perf_taken, perf_stall} !== exp_perf()) begin
                n_err++; $display("FAIL random_perf[%0d]: got %h want %h", i, {perf_br, perf_taken, perf_stall}, exp_perf());
            end
            advance();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; br_valid = 1'b0; br_type = 4'd0; rs_ready = 1'b0; rt_ready = 1'b0;
        cmp_result = 1'b0; id_stall_ext = 1'b0; ex_flush = 1'b0;
        m_hold = 0; m_held = 0; m_streak = 0; m_hang = 0; m_br = '0; m_tk = '0; m_st = '0;
        @(negedge clk);
        test_reset();
        test_beq_ready();
        test_bgtz_wait();
        test_hold();
        test_flush();
        test_hang();
        test_uncond_nonbranch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
